// File: rtl/hazard_fwd_ctrl.sv
// EX-stage forwarding select generation, load-use stall and redirect flush control.
// Tracks destination-register shadows for EX/MEM/WB alongside the ID/EX register.
module hazard_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  valid_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  use_rs1_id,
    input  logic                  use_rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  reg_write_id,
    input  logic                  mem_read_id,
    input  logic                  branch_taken_ex,
    output logic [1:0]            rs1_fwd_ex,
    output logic [1:0]            rs2_fwd_ex,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [CNT_W-1:0]      load_use_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } shadow_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    shadow_t e_q, m_q, w_q;
    shadow_t e_next;

    logic hit1_e, hit1_m, hit2_e, hit2_m;
    logic load_use, bubble;
    logic [1:0] fwd1_next, fwd2_next;

    // x0 never matches; invalid ID slots never generate hits.
    always_comb begin
        hit1_e = valid_id && use_rs1_id && (rs1_id != '0) && (rs1_id == e_q.rd) && e_q.reg_write;
        hit1_m = valid_id && use_rs1_id && (rs1_id != '0) && (rs1_id == m_q.rd) && m_q.reg_write;
        hit2_e = valid_id && use_rs2_id && (rs2_id != '0) && (rs2_id == e_q.rd) && e_q.reg_write;
        hit2_m = valid_id && use_rs2_id && (rs2_id != '0) && (rs2_id == m_q.rd) && m_q.reg_write;
    end

    assign load_use = valid_id && e_q.mem_read && (hit1_e || hit2_e);
    assign bubble   = load_use || branch_taken_ex;

    // Youngest producer wins; a load in E is never forwarded (it stalls instead).
    always_comb begin
        fwd1_next = FWD_RF;
        fwd2_next = FWD_RF;
        if (!bubble) begin
            if (hit1_e && !e_q.mem_read) fwd1_next = FWD_MEM;
            else if (hit1_m)             fwd1_next = FWD_WB;
            if (hit2_e && !e_q.mem_read) fwd2_next = FWD_MEM;
            else if (hit2_m)             fwd2_next = FWD_WB;
        end
    end

    always_comb begin
        e_next = '0;
        if (!bubble && valid_id) begin
            e_next.rd        = rd_id;
            e_next.reg_write = reg_write_id;
            e_next.mem_read  = mem_read_id;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_q        <= '0;
            m_q        <= '0;
            w_q        <= '0;
            rs1_fwd_ex <= FWD_RF;
            rs2_fwd_ex <= FWD_RF;
        end else begin
            e_q        <= e_next;
            m_q        <= e_q;
            w_q        <= m_q;
            rs1_fwd_ex <= fwd1_next;
            rs2_fwd_ex <= fwd2_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_use_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (load_use && !branch_taken_ex && (load_use_cnt != '1))
                load_use_cnt <= load_use_cnt + 1'b1;
            if (branch_taken_ex && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Redirect wins over load-use: the instruction that would stall is wrong-path.
    assign stall_pc    = rstn && load_use && !branch_taken_ex;
    assign stall_if_id = rstn && load_use && !branch_taken_ex;
    assign flush_if_id = rstn && branch_taken_ex;
    assign flush_id_ex = rstn && bubble;

    // WB results reach ID through the write-first register file, so W only shadows.
    a_wb_shift: assert property (@(posedge clk) disable iff (!rstn) w_q == $past(m_q));

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scenario bench for hazard_fwd_ctrl: hand-derived expectations queued per ID cycle.
module tb_hazard_fwd_ctrl;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic clk = 1'b0;
    logic rstn;
    logic valid_id, use_rs1_id, use_rs2_id, reg_write_id, mem_read_id, branch_taken_ex;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic [1:0] rs1_fwd_ex, rs2_fwd_ex;
    logic stall_pc, stall_if_id, flush_if_id, flush_id_ex;
    logic [CNT_W-1:0] load_use_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_lu, exp_fl;
    logic [3:0] fwd_q[$];

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .valid_id(valid_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
        .branch_taken_ex(branch_taken_ex),
        .rs1_fwd_ex(rs1_fwd_ex), .rs2_fwd_ex(rs2_fwd_ex),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
    );

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic br);
        valid_id = v; rs1_id = r1; rs2_id = r2; use_rs1_id = u1; use_rs2_id = u2;
        rd_id = rd; reg_write_id = rw; mem_read_id = mr; branch_taken_ex = br;
    endtask

    // One ID cycle: control outputs checked mid-cycle, forward selects after the edge.
    // ectl = {stall_pc, stall_if_id, flush_if_id, flush_id_ex}
    task automatic cyc(input string tag, input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic br, input logic [3:0] ectl,
                       input logic [1:0] ef1, input logic [1:0] ef2);
        logic [3:0] got, exp;
        @(negedge clk);
        drive(v, r1, r2, u1, u2, rd, rw, mr, br);
        #1;
        got = {stall_pc, stall_if_id, flush_if_id, flush_id_ex};
        n_cmp++;
        if (got !== ectl) begin
            n_err++;
            $display("FAIL %s ctl: got %b required %b", tag, got, ectl);
        end
        fwd_q.push_back({ef1, ef2});
        if (ectl[3] && exp_lu != CMAX) exp_lu = exp_lu + 1'b1;
        if (ectl[1] && exp_fl != CMAX) exp_fl = exp_fl + 1'b1;
        @(posedge clk);
        #1;
        exp = fwd_q.pop_front();
        got = {rs1_fwd_ex, rs2_fwd_ex};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s fwd: got %b required %b", tag, got, exp);
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++)
            cyc("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
    endtask

    task automatic check_cnt(input string tag);
        n_cmp++;
        if (load_use_cnt !== exp_lu) begin
            n_err++;
            $display("FAIL %s load_use_cnt: got %0d required %0d", tag, load_use_cnt, exp_lu);
        end
        n_cmp++;
        if (flush_cnt !== exp_fl) begin
            n_err++;
            $display("FAIL %s flush_cnt: got %0d required %0d", tag, flush_cnt, exp_fl);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [23:0] got;
        got = {rs1_fwd_ex, rs2_fwd_ex, stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               load_use_cnt, flush_cnt};
        n_cmp++;
        if (got !== 24'h0) begin
            n_err++;
            $display("FAIL %s outputs: got %h required 0", tag, got);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        exp_lu = '0; exp_fl = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        nops(2);
        check_cnt("reset_cnt");
    endtask

    task automatic test_back_to_back();
        cyc("add_x5", 1, 1, 2, 1, 1, 5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        cyc("add_x6_x5_x3", 1, 5, 3, 1, 1, 6, 1, 0, 0, 4'b0000, 2'b01, 2'b00);
        nops(3);
    endtask

    task automatic test_wb_fwd();
        cyc("add_x5", 1, 1, 2, 1, 1, 5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        nops(1);
        cyc("sub_x7_x4_x5", 1, 4, 5, 1, 1, 7, 1, 0, 0, 4'b0000, 2'b00, 2'b10);
        nops(3);
        // both E and M write x5: E (younger) wins
        cyc("add_x5_a", 1, 1, 2, 1, 1, 5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        cyc("add_x5_b", 1, 1, 2, 1, 1, 5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        cyc("prio_use_x5", 1, 5, 5, 1, 1, 9, 1, 0, 0, 4'b0000, 2'b01, 2'b01);
        nops(3);
        // producer in W: register file supplies the value
        cyc("add_x5_w", 1, 1, 2, 1, 1, 5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        nops(2);
        cyc("w_use_x5", 1, 5, 5, 1, 1, 9, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        nops(3);
    endtask

    task automatic test_load_use();
        cyc("lw_x8", 1, 1, 0, 1, 0, 8, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        cyc("add_x9_stall", 1, 8, 8, 1, 1, 9, 1, 0, 0, 4'b1101, 2'b00, 2'b00);
        cyc("add_x9_go", 1, 8, 8, 1, 1, 9, 1, 0, 0, 4'b0000, 2'b10, 2'b10);
        check_cnt("load_use");
        nops(3);
    endtask

    task automatic test_x0_and_invalid();
        cyc("add_x0", 1, 1, 2, 1, 1, 0, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        cyc("add_x3_x0_x0", 1, 0, 0, 1, 1, 3, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        cyc("add_x4_x0_x0", 1, 0, 0, 1, 1, 4, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        nops(3);
        cyc("lw_x0", 1, 1, 0, 1, 0, 0, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        cyc("use_x0_after_lw", 1, 0, 0, 1, 1, 3, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        nops(3);
        // invalid slot writing x6, then a real use of x6: nothing to forward
        cyc("add_x5_v", 1, 1, 2, 1, 1, 5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        cyc("invalid_uses_x5", 0, 5, 5, 1, 1, 6, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        cyc("use_x6", 1, 6, 6, 1, 1, 7, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        nops(3);
        check_cnt("x0_invalid");
    endtask

    task automatic test_redirect_over_load();
        cyc("lw_x8_r", 1, 1, 0, 1, 0, 8, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        cyc("use_x8_redirect", 1, 8, 8, 1, 1, 9, 1, 0, 1, 4'b0011, 2'b00, 2'b00);
        check_cnt("redirect");
        nops(3);
    endtask

    task automatic test_lu_saturate();
        cyc("lw_x8_x8_first", 1, 8, 0, 1, 0, 8, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        for (int i = 0; i < int'(CMAX) + 4; i++) begin
            cyc("sat_stall", 1, 8, 0, 1, 0, 8, 1, 1, 0, 4'b1101, 2'b00, 2'b00);
            cyc("sat_go", 1, 8, 0, 1, 0, 8, 1, 1, 0, 4'b0000, 2'b10, 2'b00);
        end
        check_cnt("lu_saturate");
        // E holds lw x8 again: this cycle stalls, then reset drops mid-stall
        @(negedge clk);
        drive(1, 8, 0, 1, 0, 8, 1, 1, 0);
        #1;
        n_cmp++;
        if (stall_pc !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_stall: got %b required 1", stall_pc);
        end
        rstn = 1'b0;
        #1;
        check_all_zero("reset_mid_stall");
        exp_lu = '0; exp_fl = '0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++;
        if ({stall_pc, stall_if_id, flush_if_id, flush_id_ex} !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset_empty: got %b required 0000",
                     {stall_pc, stall_if_id, flush_if_id, flush_id_ex});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({rs1_fwd_ex, rs2_fwd_ex} !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset_fwd: got %b required 0000", {rs1_fwd_ex, rs2_fwd_ex});
        end
        nops(3);
        check_cnt("post_reset_cnt");
    endtask

    task automatic test_flush_saturate();
        for (int i = 0; i < int'(CMAX) + 3; i++)
            cyc("flush_hold", 1, 8, 0, 1, 0, 8, 1, 1, 1, 4'b0011, 2'b00, 2'b00);
        check_cnt("flush_saturate");
        @(negedge clk);
        drive(1, 8, 8, 1, 1, 9, 1, 0, 1);
        rstn = 1'b0;
        #1;
        check_all_zero("reset_mid_flush");
        exp_lu = '0; exp_fl = '0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        nops(2);
        check_cnt("post_flush_reset");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wb_fwd();
        test_load_use();
        test_x0_and_invalid();
        test_redirect_over_load();
        test_lu_saturate();
        test_flush_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
